cpu_controller: RTL and testbench

CPU_CONTROLLER -- requirements
Module: cpu_controller

---
 rtl/cpu_pkg.sv | 48 ++++
 rtl/cpu_controller_if.sv | 28 ++
 rtl/cpu_controller.sv | 119 +++++++++++
 tb/tb_cpu_controller.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the instruction-sequencing controller: state enum,
// opcode/op fields, register-select and writeback-source codes.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_DECODE    = 3'd1,
    S_GET_A     = 3'd2,
    S_GET_B     = 3'd3,
    S_EXEC      = 3'd4,
    S_WRITE_REG = 3'd5,
    S_WRITE_IMM = 3'd6
  } state_e;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  // Full {opcode,op} values as seen by the decode state.
  localparam logic [4:0] I_MOV_IMM = {OPC_MOV, OP_MOV_IMM};
  localparam logic [4:0] I_MOV_REG = {OPC_MOV, OP_MOV_REG};
  localparam logic [4:0] I_ADD     = {OPC_ALU, OP_ADD};
  localparam logic [4:0] I_CMP     = {OPC_ALU, OP_CMP};
  localparam logic [4:0] I_AND     = {OPC_ALU, OP_AND};
  localparam logic [4:0] I_MVN     = {OPC_ALU, OP_MVN};

  localparam logic [2:0] NSEL_NONE = 3'b000;
  localparam logic [2:0] NSEL_RN   = 3'b001;
  localparam logic [2:0] NSEL_RM   = 3'b010;
  localparam logic [2:0] NSEL_RD   = 3'b100;

  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_PC    = 2'b01;
  localparam logic [1:0] VSEL_IMM   = 2'b10;
  localparam logic [1:0] VSEL_MDATA = 2'b11;

  // Single-operand instructions pass B through the ALU with A forced to zero.
  function automatic logic uses_zero_a(input logic [4:0] instr);
    return (instr == I_MOV_REG) || (instr == I_MVN);
  endfunction

endpackage

// File: rtl/cpu_controller_if.sv
// Controller <-> decoder/datapath signal bundle: start/instruction fields in,
// register selects, load enables and writeback controls out.
interface cpu_controller_if;
  logic       s;
  logic [2:0] opcode;
  logic [1:0] op;
  logic       w;
  logic [2:0] nsel;
  logic       loada;
  logic       loadb;
  logic       loadc;
  logic       loads;
  logic       asel;
  logic       bsel;
  logic [1:0] vsel;
  logic       write;
  logic       err;

  modport master (
    output s, opcode, op,
    input  w, nsel, loada, loadb, loadc, loads, asel, bsel, vsel, write, err
  );

  modport slave (
    input  s, opcode, op,
    output w, nsel, loada, loadb, loadc, loads, asel, bsel, vsel, write, err
  );
endinterface

// File: rtl/cpu_controller.sv
// Moore FSM sequencing the datapath through MOV/ADD/CMP/AND/MVN; outputs are a
// pure decode of the state and latched instruction, so reset clears them at once.
module cpu_controller (
  input  logic            clk,
  input  logic            rst_n,
  cpu_controller_if.slave bus
);
  import cpu_pkg::*;

  state_e     state_q, state_d;
  logic [4:0] instr_q, instr_d;

  logic       w;
  logic [2:0] nsel;
  logic       loada, loadb, loadc, loads;
  logic       asel, bsel;
  logic [1:0] vsel;
  logic       write;
  logic       err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_WAIT;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
    end
  end

  // Instruction fields are sampled only when leaving S_WAIT, so the decoder
  // inputs are free to change while an instruction is in flight.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    case (state_q)
      S_WAIT: begin
        if (bus.s) begin
          state_d = S_DECODE;
          instr_d = {bus.opcode, bus.op};
        end
      end
      S_DECODE: begin
        case (instr_q)
          I_MOV_IMM:              state_d = S_WRITE_IMM;
          I_MOV_REG, I_MVN:       state_d = S_GET_B;
          I_ADD, I_CMP, I_AND:    state_d = S_GET_A;
          default:                state_d = S_WAIT;
        endcase
      end
      S_GET_A:     state_d = S_GET_B;
      S_GET_B:     state_d = S_EXEC;
      S_EXEC:      state_d = (instr_q == I_CMP) ? S_WAIT : S_WRITE_REG;
      S_WRITE_REG: state_d = S_WAIT;
      S_WRITE_IMM: state_d = S_WAIT;
      default:     state_d = S_WAIT;
    endcase
  end

  always_comb begin
    w     = 1'b0;
    nsel  = NSEL_NONE;
    loada = 1'b0;
    loadb = 1'b0;
    loadc = 1'b0;
    loads = 1'b0;
    asel  = 1'b0;
    bsel  = 1'b0;
    vsel  = VSEL_C;
    write = 1'b0;
    err   = 1'b0;
    case (state_q)
      S_WAIT: w = 1'b1;
      S_DECODE: begin
        case (instr_q)
          I_MOV_IMM, I_MOV_REG, I_MVN, I_ADD, I_CMP, I_AND: err = 1'b0;
          default:                                          err = 1'b1;
        endcase
      end
      S_GET_A: begin
        nsel  = NSEL_RN;
        loada = 1'b1;
      end
      S_GET_B: begin
        nsel  = NSEL_RM;
        loadb = 1'b1;
      end
      S_EXEC: begin
        asel = uses_zero_a(instr_q);
        if (instr_q == I_CMP) loads = 1'b1;
        else                  loadc = 1'b1;
      end
      S_WRITE_REG: begin
        nsel  = NSEL_RD;
        vsel  = VSEL_C;
        write = 1'b1;
      end
      S_WRITE_IMM: begin
        nsel  = NSEL_RN;
        vsel  = VSEL_IMM;
        write = 1'b1;
      end
      default: w = 1'b0;
    endcase
  end

  assign bus.w     = w;
  assign bus.nsel  = nsel;
  assign bus.loada = loada;
  assign bus.loadb = loadb;
  assign bus.loadc = loadc;
  assign bus.loads = loads;
  assign bus.asel  = asel;
  assign bus.bsel  = bsel;
  assign bus.vsel  = vsel;
  assign bus.write = write;
  assign bus.err   = err;

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller: per-cycle output traces compared against
// hand-written expected sequences for each instruction class and reset case.
module tb_cpu_controller;

  logic clk;
  logic rst_n;
  cpu_controller_if bus_if ();

  cpu_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Packed output snapshot: {w, nsel, loada, loadb, loadc, loads, asel, bsel, vsel, write, err}
  logic [13:0] tr [0:9];
  logic [13:0] IDLE, DEC, DEC_ERR, GETA, GETB, EXEC_C0, EXEC_C1, EXEC_S, WREG, WIMM;

  function automatic logic [13:0] pk(input logic w, input logic [2:0] ns,
                                     input logic la, input logic lb, input logic lc,
                                     input logic ls, input logic as_,
                                     input logic [1:0] vs, input logic wr, input logic er);
    return {w, ns, la, lb, lc, ls, as_, 1'b0, vs, wr, er};
  endfunction

  function automatic logic [13:0] snap();
    return {bus_if.w, bus_if.nsel, bus_if.loada, bus_if.loadb, bus_if.loadc,
            bus_if.loads, bus_if.asel, bus_if.bsel, bus_if.vsel, bus_if.write, bus_if.err};
  endfunction

  // Starts one instruction at the next falling edge and records n+1 cycles.
  task automatic run_instr(input logic [2:0] opc0, input logic [1:0] op0,
                           input logic [2:0] opc1, input logic [1:0] op1,
                           input logic hold_s, input int n);
    @(negedge clk);
    tr[0] = snap();
    bus_if.s = 1'b1; bus_if.opcode = opc0; bus_if.op = op0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      tr[k] = snap();
      bus_if.s = hold_s; bus_if.opcode = opc1; bus_if.op = op1;
    end
    bus_if.s = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (snap() !== IDLE) begin errors++; $display("FAIL reset_hold got=%h exp=%h", snap(), IDLE); end
    @(negedge clk);
    checks++;
    if (snap() !== IDLE) begin errors++; $display("FAIL reset_hold_clk got=%h exp=%h", snap(), IDLE); end
    @(negedge clk); rst_n = 1'b1;
    // ADD, interrupted by reset in S_EXEC
    @(negedge clk); bus_if.s = 1'b1; bus_if.opcode = 3'b101; bus_if.op = 2'b00;
    @(negedge clk); bus_if.s = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (snap() !== EXEC_C0) begin errors++; $display("FAIL reset_pre_exec got=%h exp=%h", snap(), EXEC_C0); end
    rst_n = 1'b0; #1;
    checks++;
    if (snap() !== IDLE) begin errors++; $display("FAIL reset_async_exec got=%h exp=%h", snap(), IDLE); end
    @(negedge clk);
    checks++;
    if (snap() !== IDLE) begin errors++; $display("FAIL reset_held_exec got=%h exp=%h", snap(), IDLE); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (snap() !== IDLE) begin errors++; $display("FAIL reset_release_wait got=%h exp=%h", snap(), IDLE); end
    // ADD, interrupted by reset in S_WRITE_REG
    bus_if.s = 1'b1; bus_if.opcode = 3'b101; bus_if.op = 2'b00;
    @(negedge clk); bus_if.s = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (snap() !== WREG) begin errors++; $display("FAIL reset_pre_write got=%h exp=%h", snap(), WREG); end
    rst_n = 1'b0; #1;
    checks++;
    if (bus_if.write !== 1'b0 || snap() !== IDLE) begin
      errors++; $display("FAIL reset_async_write got=%h exp=%h", snap(), IDLE);
    end
    @(negedge clk); rst_n = 1'b1;
    run_instr(3'b110, 2'b10, 3'b000, 2'b00, 1'b0, 2);
    checks++;
    if (tr[1] !== DEC || tr[2] !== WIMM) begin
      errors++; $display("FAIL reset_first_start got=%h,%h exp=%h,%h", tr[1], tr[2], DEC, WIMM);
    end
  endtask

  task automatic test_wait_ignores();
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      bus_if.s = 1'b0; bus_if.opcode = 3'(k + 3); bus_if.op = 2'(k);
      @(negedge clk);
      checks++;
      if (snap() !== IDLE) begin errors++; $display("FAIL wait_idle_%0d got=%h exp=%h", k, snap(), IDLE); end
    end
  endtask

  task automatic test_mov_imm();
    logic [13:0] exp [0:4];
    int lat, nwr;
    exp = '{IDLE, DEC, WIMM, IDLE, IDLE};
    run_instr(3'b110, 2'b10, 3'b011, 2'b00, 1'b0, 4);
    lat = -1; nwr = 0;
    for (int k = 0; k <= 4; k++) begin
      checks++;
      if (tr[k] !== exp[k]) begin errors++; $display("FAIL mov_imm_c%0d got=%h exp=%h", k, tr[k], exp[k]); end
      if (k > 0 && tr[k][13] && lat < 0) lat = k;
      nwr += int'(tr[k][1]);
    end
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL mov_imm_latency got=%0d exp=3", lat); end
    checks++;
    if (nwr !== 1) begin errors++; $display("FAIL mov_imm_writes got=%0d exp=1", nwr); end
  endtask

  task automatic test_add();
    logic [13:0] exp [0:7];
    int lat, nwr;
    exp = '{IDLE, DEC, GETA, GETB, EXEC_C0, WREG, IDLE, IDLE};
    // decoder inputs switch to CMP after the start; the latched ADD must win
    run_instr(3'b101, 2'b00, 3'b101, 2'b01, 1'b0, 7);
    lat = -1; nwr = 0;
    for (int k = 0; k <= 7; k++) begin
      checks++;
      if (tr[k] !== exp[k]) begin errors++; $display("FAIL add_c%0d got=%h exp=%h", k, tr[k], exp[k]); end
      if (k > 0 && tr[k][13] && lat < 0) lat = k;
      nwr += int'(tr[k][1]);
    end
    checks++;
    if (lat !== 6) begin errors++; $display("FAIL add_latency got=%0d exp=6", lat); end
    checks++;
    if (nwr !== 1) begin errors++; $display("FAIL add_writes got=%0d exp=1", nwr); end
  endtask

  task automatic test_and();
    logic [13:0] exp [0:6];
    exp = '{IDLE, DEC, GETA, GETB, EXEC_C0, WREG, IDLE};
    run_instr(3'b101, 2'b10, 3'b110, 2'b10, 1'b0, 6);
    for (int k = 0; k <= 6; k++) begin
      checks++;
      if (tr[k] !== exp[k]) begin errors++; $display("FAIL and_c%0d got=%h exp=%h", k, tr[k], exp[k]); end
    end
  endtask

  task automatic test_cmp();
    logic [13:0] exp [0:6];
    int lat, nwr, nlc;
    exp = '{IDLE, DEC, GETA, GETB, EXEC_S, IDLE, IDLE};
    run_instr(3'b101, 2'b01, 3'b101, 2'b00, 1'b0, 6);
    lat = -1; nwr = 0; nlc = 0;
    for (int k = 0; k <= 6; k++) begin
      checks++;
      if (tr[k] !== exp[k]) begin errors++; $display("FAIL cmp_c%0d got=%h exp=%h", k, tr[k], exp[k]); end
      if (k > 0 && tr[k][13] && lat < 0) lat = k;
      nwr += int'(tr[k][1]);
      nlc += int'(tr[k][7]);
    end
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL cmp_latency got=%0d exp=5", lat); end
    checks++;
    if (nwr !== 0 || nlc !== 0) begin errors++; $display("FAIL cmp_no_write got=%0d/%0d exp=0/0", nwr, nlc); end
  endtask

  task automatic test_mov_reg();
    logic [13:0] exp [0:5];
    exp = '{IDLE, DEC, GETB, EXEC_C1, WREG, IDLE};
    run_instr(3'b110, 2'b00, 3'b101, 2'b00, 1'b0, 5);
    for (int k = 0; k <= 5; k++) begin
      checks++;
      if (tr[k] !== exp[k]) begin errors++; $display("FAIL mov_reg_c%0d got=%h exp=%h", k, tr[k], exp[k]); end
    end
  endtask

  task automatic test_illegal();
    logic [13:0] exp [0:3];
    logic [4:0] bad [0:2];
    exp = '{IDLE, DEC_ERR, IDLE, IDLE};
    bad = '{5'b011_00, 5'b110_01, 5'b111_11};
    for (int v = 0; v < 3; v++) begin
      run_instr(bad[v][4:2], bad[v][1:0], 3'b110, 2'b10, 1'b0, 3);
      for (int k = 0; k <= 3; k++) begin
        checks++;
        if (tr[k] !== exp[k]) begin
          errors++; $display("FAIL illegal%0d_c%0d got=%h exp=%h", v, k, tr[k], exp[k]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [13:0] exp [0:8];
    int nwr;
    exp = '{IDLE, DEC, GETB, EXEC_C1, WREG, IDLE, DEC, WIMM, IDLE};
    // MVN start, then s held high with MOV imm presented during MVN
    run_instr(3'b101, 2'b11, 3'b110, 2'b10, 1'b1, 8);
    nwr = 0;
    for (int k = 0; k <= 8; k++) begin
      checks++;
      if (tr[k] !== exp[k]) begin errors++; $display("FAIL b2b_c%0d got=%h exp=%h", k, tr[k], exp[k]); end
      nwr += int'(tr[k][1]);
    end
    checks++;
    if (nwr !== 2) begin errors++; $display("FAIL b2b_writes got=%0d exp=2", nwr); end
  endtask

  initial begin
    rst_n = 1'b0;
    bus_if.s = 1'b0; bus_if.opcode = 3'b000; bus_if.op = 2'b00;
    IDLE    = pk(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    DEC     = pk(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    DEC_ERR = pk(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
    GETA    = pk(1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    GETB    = pk(1'b0, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    EXEC_C0 = pk(1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    EXEC_C1 = pk(1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
    EXEC_S  = pk(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    WREG    = pk(1'b0, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    WIMM    = pk(1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0);

    test_reset();
    test_wait_ignores();
    test_mov_imm();
    test_add();
    test_and();
    test_cmp();
    test_mov_reg();
    test_illegal();
    test_back_to_back();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
